mem_stream_reader: RTL

- Avalon-MM read master that sits directly in front of the on-chip RAM (13-bit word address, 32-bit data, 5000 words, single port).
- Fetches a CPU-programmed block of consecutive words and emits them as an Avalon-ST packet.
- Controlled through a small CSR slave on the same SOPC interconnect.
- Handles the RAM's fixed 1-cycle read latency and downstream backpressure without losing words.

---
 rtl/mem_stream_reader_pkg.sv | 23 ++
 rtl/mem_stream_fifo2.sv | 48 ++++
 rtl/mem_stream_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stream_reader_pkg.sv
// Shared constants and types for the memory stream reader.
// CSR offsets, CONTROL/STATUS bit positions and the FSM state type.
package mem_stream_reader_pkg;

    localparam logic [1:0] CSR_START  = 2'd0;
    localparam logic [1:0] CSR_LEN    = 2'd1;
    localparam logic [1:0] CSR_CTRL   = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int CTRL_GO  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

endpackage

// File: rtl/mem_stream_fifo2.sv
// Two-entry synchronous FIFO holding RAM words ahead of the stream port.
// Ports: push/push_data in, pop in, rd_data (head), full, empty, count.
module mem_stream_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = slot[rd_ptr];
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);

endmodule

// File: rtl/mem_stream_reader.sv
// Avalon-MM read master that streams a CSR-programmed RAM block as a packet.
// Ports: csr_* slave, mem_* RAM master (1-cycle latency), src_* Avalon-ST source.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int DEPTH  = 5000,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_startofpacket,
    output logic              src_endofpacket
);

    state_t            state;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  beats;
    logic              busy;
    logic              done;
    logic              error;
    logic              outstanding;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              issue;
    logic [2:0]        slots_used;
    logic [2:0]        slots_avail;
    logic [LEN_W:0]    end_sum;
    logic              csr_wr;
    logic              csr_rd;
    logic              go_req;
    logic              clr_req;
    logic [31:0]       status_word;

    assign csr_wr  = csr_chipselect & csr_write;
    assign csr_rd  = csr_chipselect & csr_read;
    assign go_req  = csr_wr && (csr_address == CSR_CTRL)
                     && csr_writedata[CTRL_GO];
    assign clr_req = csr_wr && (csr_address == CSR_CTRL)
                     && csr_writedata[CTRL_CLR];

    assign end_sum = (LEN_W+1)'(start_addr) + (LEN_W+1)'(length);

    assign pop = src_valid & src_ready;

    // A slot freed by this cycle's pop counts as available, which keeps
    // one read per cycle flowing while the sink accepts every beat.
    assign slots_used  = {1'b0, fifo_count} + {2'b00, outstanding};
    assign slots_avail = 3'd2 + {2'b00, pop};
    assign issue       = (state == ISSUE) && (slots_used < slots_avail);

    assign mem_chipselect = issue;
    assign mem_address    = issue ? start_addr + ADDR_W'(issued) : '0;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    mem_stream_fifo2 #(
        .W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (outstanding),
        .push_data (mem_readdata),
        .pop       (pop),
        .rd_data   (src_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign src_valid         = ~fifo_empty;
    assign src_startofpacket = src_valid && (beats == '0);
    assign src_endofpacket   = src_valid && (beats == length - 1'b1);

    always_comb begin
        status_word          = '0;
        status_word[ST_BUSY] = busy;
        status_word[ST_DONE] = done;
        status_word[ST_ERR]  = error;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            start_addr   <= '0;
            length       <= '0;
            issued       <= '0;
            beats        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            outstanding  <= 1'b0;
            csr_readdata <= '0;
        end else begin
            outstanding <= issue;
            if (pop) begin
                beats <= beats + 1'b1;
            end

            if (csr_wr && !busy) begin
                if (csr_address == CSR_START) begin
                    start_addr <= csr_writedata[ADDR_W-1:0];
                end
                if (csr_address == CSR_LEN) begin
                    length <= csr_writedata[LEN_W-1:0];
                end
            end

            if (clr_req) begin
                done  <= 1'b0;
                error <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (go_req) begin
                        if (length == '0) begin
                            done  <= 1'b1;
                            error <= 1'b0;
                        end else if (end_sum > (LEN_W+1)'(DEPTH)) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            error  <= 1'b0;
                            issued <= '0;
                            beats  <= '0;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        issued <= issued + 1'b1;
                        if (issued == length - 1'b1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !outstanding) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (csr_rd) begin
                unique case (csr_address)
                    CSR_START:  csr_readdata <= 32'(start_addr);
                    CSR_LEN:    csr_readdata <= 32'(length);
                    CSR_STATUS: csr_readdata <= status_word;
                    default:    csr_readdata <= '0;
                endcase
            end
        end
    end

endmodule
